// File: rtl/lifo_frame_reverser_if.sv
// Stream bundle for the frame reverser: one valid/ready input stream and one
// valid/ready output stream. The slave modport is the reverser's own view.
interface lifo_frame_reverser_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/lifo_frame_reverser.sv
// Frame reverser: pushes one last-delimited frame onto a stack, then pops it out
// in reverse order. Filling and draining never overlap.
module lifo_frame_reverser #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  lifo_frame_reverser_if.slave  s,
  output logic                  overflow,
  output logic                  busy,
  output logic                  dbg_draining,
  output logic [ADDR_WIDTH:0]   dbg_count
);
  // Handshake: a word moves on a rising edge where valid && ready are both high.
  // valid never depends on ready, and a presented word is held until taken.

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_d;
  logic                  push;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Low bits of count address the stack; count==DEPTH wraps to the top entry.
  assign wr_addr = count_q[ADDR_WIDTH-1:0];
  assign rd_addr = count_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    push        = 1'b0;
    s.in_ready  = 1'b0;
    s.out_valid = 1'b0;
    s.out_data  = '0;
    s.out_last  = 1'b0;
    case (state_q)
      FILL: begin
        s.in_ready = (count_q < DEPTH_C);
        push       = s.in_valid && s.in_ready;
        if (push) begin
          count_d = count_q + ONE_C;
          if (s.in_last) begin
            state_d = DRAIN;
          end else if (count_d == DEPTH_C) begin
            state_d    = DRAIN;
            overflow_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        s.out_valid = 1'b1;
        s.out_data  = mem[rd_addr];
        s.out_last  = (count_q == ONE_C);
        if (s.out_ready) begin
          count_d = count_q - ONE_C;
          if (s.out_last) state_d = FILL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      overflow <= overflow_d;
    end
  end

  // Stack storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= s.in_data;
  end

  assign busy         = (state_q == DRAIN) || (count_q != '0);
  assign dbg_draining = (state_q == DRAIN);
  assign dbg_count    = count_q;
endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Bench for lifo_frame_reverser (DEPTH=4): directed frames plus random frames
// scored against a chunk-and-reverse model of the expected output stream.
module tb_lifo_frame_reverser;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          overflow, busy, dbg_draining;
  logic [AW:0]   dbg_count;

  lifo_frame_reverser_if #(.DATA_WIDTH(W)) bus ();

  lifo_frame_reverser #(.DATA_WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (bus),
    .overflow     (overflow),
    .busy         (busy),
    .dbg_draining (dbg_draining),
    .dbg_count    (dbg_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  bit           exp_last_q[$];
  logic [W-1:0] in_q[$];
  bit           last_q[$];
  logic [W-1:0] frame_q[$];
  bit           rdy_q[$];

  int  exp_ovf = 0, ovf_seen = 0, pops = 0, holds = 0, acc_cnt = 0;
  int  in_pct = 100, rdy_pct = 100;
  bit  pres = 0;
  bit  prev_go_drain = 0, prev_pop = 0, prev_pop_last = 0, prev_hold = 0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Model: a frame is cut into DEPTH-sized pieces; each piece comes out reversed,
  // and a full piece that does not end the frame causes one overflow pulse.
  task automatic add_frame();
    int n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      in_q.push_back(frame_q[i]);
      last_q.push_back(i == n - 1);
    end
    for (int k = 0; k < n; k += DEPTH) begin
      int m = (n - k < DEPTH) ? n - k : DEPTH;
      if (m == DEPTH && k + m < n) exp_ovf++;
      for (int j = m - 1; j >= 0; j--) begin
        exp_q.push_back(frame_q[k + j]);
        exp_last_q.push_back(j == 0);
      end
    end
    frame_q.delete();
  endtask

  task automatic clear_tracking();
    prev_go_drain = 0; prev_pop = 0; prev_pop_last = 0; prev_hold = 0;
    pres = 0; acc_cnt = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (in_q.size() > 0) begin
      if (!pres) pres = ($urandom_range(0, 99) < in_pct);
    end else begin
      pres = 0;
    end
    bus.in_valid  = pres;
    bus.in_data   = pres ? in_q[0] : W'($urandom);
    bus.in_last   = pres ? last_q[0] : 1'b0;
    bus.out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : ($urandom_range(0, 99) < rdy_pct);
    #1;
    if (prev_go_drain) chk("latency_out_valid", bus.out_valid, 1);
    if (prev_pop && !prev_pop_last) chk("no_bubble", bus.out_valid, 1);
    if (prev_pop && prev_pop_last) begin
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_in_ready", bus.in_ready, 1);
    end
    if (prev_hold) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, prev_data);
    end
    if (bus.out_valid) begin
      chk("in_ready_in_drain", bus.in_ready, 0);
      chk("busy_in_drain", busy, 1);
    end
    if (overflow) ovf_seen++;
    prev_go_drain = 0; prev_pop = 0; prev_hold = 0;
    if (bus.in_valid && bus.in_ready) begin
      void'(in_q.pop_front());
      void'(last_q.pop_front());
      pres = 0;
      acc_cnt++;
      prev_go_drain = bus.in_last || (acc_cnt == DEPTH);
      if (prev_go_drain) acc_cnt = 0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        chk("out_data", bus.out_data, exp_q.pop_front());
        chk("out_last", bus.out_last, exp_last_q.pop_front());
      end
      prev_pop = 1;
      prev_pop_last = bus.out_last;
      pops++;
    end else if (bus.out_valid) begin
      prev_hold = 1;
      prev_data = bus.out_data;
      holds++;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("timeout_pending", exp_q.size() + in_q.size(), 0);
  endtask

  initial begin
    int guard;
    int p0;
    int h0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    // Idle after reset release
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", dbg_count, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);

    // Basic reversal of 100,150,200
    frame_q = '{8'd100, 8'd150, 8'd200};
    add_frame();
    run_until_idle(40);
    cycle();

    // Backpressure mid-drain: three stalled cycles on 150
    frame_q = '{8'd100, 8'd150, 8'd200};
    add_frame();
    guard = 0;
    while (in_q.size() > 0 && guard < 40) begin cycle(); guard++; end
    h0 = holds;
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_until_idle(40);
    chk("stall_hold_cycles", holds - h0, 3);
    cycle();

    // Overflow: 1..6 into a 4-deep stack
    frame_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    add_frame();
    run_until_idle(60);
    cycle();
    chk("ovf_count_t3", ovf_seen, exp_ovf);

    // Back-to-back frames
    frame_q = '{8'd10, 8'd11};
    add_frame();
    frame_q = '{8'd20};
    add_frame();
    run_until_idle(60);
    cycle();

    // Reset mid-drain after the first pop
    frame_q = '{8'd100, 8'd150, 8'd200};
    add_frame();
    p0 = pops;
    guard = 0;
    while (pops < p0 + 1 && guard < 40) begin cycle(); guard++; end
    chk("t5_first_pop_seen", pops - p0, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_count", dbg_count, 0);
    chk("t5_busy", busy, 0);
    exp_q.delete(); exp_last_q.delete(); in_q.delete(); last_q.delete();
    clear_tracking();
    bus.in_valid = 0;
    @(negedge clk);
    rst = 0;
    frame_q = '{8'd7};
    add_frame();
    run_until_idle(30);
    cycle();

    // Random frames with random gaps and backpressure
    in_pct = 70;
    rdy_pct = 70;
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) frame_q.push_back(W'($urandom));
      add_frame();
    end
    run_until_idle(3000);
    repeat (2) cycle();
    chk("ovf_count_final", ovf_seen, exp_ovf);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
